// File: rtl/gtfwizard_raw_buffbypass_tx_retry_ctrl.sv
// TX buffer-bypass alignment sequencer: resets the bypass block, waits a holdoff, starts it,
// and retries on error or timeout until aligned or out of attempts.
module gtfwizard_raw_buffbypass_tx_retry_ctrl #(
    parameter int unsigned P_MAX_RETRIES    = 3,
    parameter int unsigned P_HOLDOFF_CYCLES = 64,
    parameter int unsigned P_TIMEOUT_CYCLES = 4096
) (
    input  logic       gtwiz_buffbypass_tx_clk_in,
    input  logic       gtwiz_buffbypass_tx_reset_in,
    input  logic       tx_resetdone_in,
    input  logic       user_start_in,
    input  logic       bb_done_in,
    input  logic       bb_error_in,
    output logic       bb_reset_out,
    output logic       bb_start_out,
    output logic       aligned_out,
    output logic       fail_out,
    output logic       busy_out,
    output logic [3:0] retry_count_out
);

    typedef enum logic [2:0] {
        StIdle, StBbReset, StHoldoff, StStart, StWaitDone, StCheck, StAligned, StFailed
    } state_e;

    localparam logic [15:0] HoldLast    = 16'(P_HOLDOFF_CYCLES - 1);
    localparam logic [15:0] TimeoutLast = 16'(P_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  MaxRetries  = 4'(P_MAX_RETRIES);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic        aligned_q, aligned_d;
    logic        fail_q, fail_d;
    logic        arm_q, arm_d;
    logic        attempt_fail;

    always_ff @(posedge gtwiz_buffbypass_tx_clk_in) begin
        if (gtwiz_buffbypass_tx_reset_in) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            retry_q   <= '0;
            aligned_q <= 1'b0;
            fail_q    <= 1'b0;
            arm_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            aligned_q <= aligned_d;
            fail_q    <= fail_d;
            arm_q     <= arm_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        aligned_d    = aligned_q;
        fail_d       = fail_q;
        arm_d        = arm_q | ~tx_resetdone_in;
        attempt_fail = 1'b0;
        if (!tx_resetdone_in) begin
            // Losing reset-done aborts everything but keeps the retry count for inspection.
            state_d   = StIdle;
            aligned_d = 1'b0;
            fail_d    = 1'b0;
        end else begin
            case (state_q)
                StIdle, StAligned, StFailed: begin
                    if (arm_q || user_start_in) begin
                        state_d   = StBbReset;
                        retry_d   = '0;
                        aligned_d = 1'b0;
                        fail_d    = 1'b0;
                        arm_d     = 1'b0;
                    end
                end
                StBbReset: begin
                    state_d = StHoldoff;
                    cnt_d   = '0;
                end
                StHoldoff: begin
                    if (cnt_q >= HoldLast) state_d = StStart;
                    else                   cnt_d   = cnt_q + 16'd1;
                end
                StStart: begin
                    state_d = StWaitDone;
                    cnt_d   = '0;
                end
                StWaitDone: begin
                    if (bb_done_in)                state_d      = StCheck;
                    else if (cnt_q >= TimeoutLast) attempt_fail = 1'b1;
                    else                           cnt_d        = cnt_q + 16'd1;
                end
                StCheck: begin
                    if (bb_error_in) begin
                        attempt_fail = 1'b1;
                    end else begin
                        state_d   = StAligned;
                        aligned_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (attempt_fail) begin
                if (retry_q < MaxRetries) begin
                    retry_d = retry_q + 4'd1;
                    state_d = StBbReset;
                end else begin
                    state_d = StFailed;
                    fail_d  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bb_reset_out    = (state_q == StBbReset);
        bb_start_out    = (state_q == StStart);
        busy_out        = state_q inside {StBbReset, StHoldoff, StStart, StWaitDone, StCheck};
        aligned_out     = aligned_q;
        fail_out        = fail_q;
        retry_count_out = retry_q;
    end

endmodule

// File: tb/tb_gtfwizard_raw_buffbypass_tx_retry_ctrl.sv
// Bench for the TX buffer-bypass retry sequencer: a responder models the bypass block, a table of
// scenarios feeds a scoreboard, and hand-written sequences cover reset-done loss and sync reset.
module tb_gtfwizard_raw_buffbypass_tx_retry_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_resetdone_in;
    logic       user_start_in;
    logic       bb_done_in;
    logic       bb_error_in;
    logic       bb_reset_out;
    logic       bb_start_out;
    logic       aligned_out;
    logic       fail_out;
    logic       busy_out;
    logic [3:0] retry_count_out;

    gtfwizard_raw_buffbypass_tx_retry_ctrl dut (
        .gtwiz_buffbypass_tx_clk_in  (clk),
        .gtwiz_buffbypass_tx_reset_in(rst),
        .tx_resetdone_in             (tx_resetdone_in),
        .user_start_in               (user_start_in),
        .bb_done_in                  (bb_done_in),
        .bb_error_in                 (bb_error_in),
        .bb_reset_out                (bb_reset_out),
        .bb_start_out                (bb_start_out),
        .aligned_out                 (aligned_out),
        .fail_out                    (fail_out),
        .busy_out                    (busy_out),
        .retry_count_out             (retry_count_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Responder configuration and monitor counters.
    int r_delay = 5;
    int r_errs  = 0;
    bit r_hang  = 1'b0;
    int attempt = 0;
    int cd      = 0;
    int n_starts = 0;
    int n_resets = 0;
    int rst_cyc  = 0;
    int last_gap = 0;
    int viol     = 0;

    initial begin
        bb_done_in  = 1'b0;
        bb_error_in = 1'b0;
        forever begin
            @(negedge clk);
            bb_done_in = 1'b0;
            if (rst) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        bb_done_in  = 1'b1;
                        bb_error_in = (attempt <= r_errs);
                    end
                end
                if (bb_start_out) begin
                    attempt++;
                    if (!(r_hang && attempt > r_errs)) cd = r_delay;
                end
            end
            if (bb_start_out && bb_reset_out) viol++;
            if (aligned_out && fail_out) viol++;
            if (bb_reset_out) begin
                n_resets++;
                rst_cyc = cyc;
            end
            if (bb_start_out) begin
                n_starts++;
                last_gap = cyc - rst_cyc - 1;
            end
        end
    end

    typedef struct {
        bit use_user;
        int delay;
        int errs;
        bit hang;
        bit poke;
        bit exp_aligned;
        bit exp_fail;
        int exp_retry;
        int exp_starts;
    } vec_t;

    typedef struct {
        bit aligned;
        bit fail;
        int retry;
        int starts;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    task automatic run_seq(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        int   k;
        sb.push_back('{v.exp_aligned, v.exp_fail, v.exp_retry, v.exp_starts});
        r_delay  = v.delay;
        r_errs   = v.errs;
        r_hang   = v.hang;
        attempt  = 0;
        n_starts = 0;
        if (v.use_user) begin
            user_start_in = 1'b1;
            @(negedge clk);
            user_start_in = 1'b0;
        end else begin
            tx_resetdone_in = 1'b0;
            @(negedge clk);
            @(negedge clk);
            tx_resetdone_in = 1'b1;
        end
        k = 0;
        while (!busy_out && k < 8) begin
            @(negedge clk);
            k++;
        end
        check({tag, " sequence began"}, int'(busy_out), 1);
        k = 0;
        while (busy_out && k < 40000) begin
            user_start_in = v.poke && (k == 10);
            @(negedge clk);
            k++;
        end
        user_start_in = 1'b0;
        check({tag, " sequence ended in budget"}, int'(busy_out), 0);
        got = '{aligned_out, fail_out, int'(retry_count_out), n_starts};
        e = sb.pop_front();
        check({tag, " aligned"}, int'(got.aligned), int'(e.aligned));
        check({tag, " fail"}, int'(got.fail), int'(e.fail));
        check({tag, " retry_count"}, got.retry, e.retry);
        check({tag, " start pulses"}, got.starts, e.starts);
        check({tag, " holdoff gap"}, last_gap, 64);
    endtask

    int k;
    int s;
    int bad;
    vec_t again;

    initial begin
        // {user, delay, errs, hang, poke, aligned, fail, retry, starts}
        vecs[0] = '{1'b0, 5, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1};  // nominal via arm
        vecs[1] = '{1'b1, 5, 2, 1'b0, 1'b0, 1'b1, 1'b0, 2, 3};  // user start from ALIGNED
        vecs[2] = '{1'b0, 1, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 2};  // poke while busy ignored
        vecs[3] = '{1'b1, 3, 3, 1'b0, 1'b0, 1'b1, 1'b0, 3, 4};  // success on last retry
        vecs[4] = '{1'b1, 5, 4, 1'b0, 1'b0, 1'b0, 1'b1, 3, 4};  // all attempts error
        vecs[5] = '{1'b1, 5, 0, 1'b1, 1'b0, 1'b0, 1'b1, 3, 4};  // all attempts time out
        vecs[6] = '{1'b0, 5, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1};
        again = vecs[6];

        rst             = 1'b1;
        tx_resetdone_in = 1'b0;
        user_start_in   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", int'({bb_reset_out, bb_start_out, aligned_out, fail_out,
                                     busy_out, retry_count_out}), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_seq(vecs[i], $sformatf("vec%0d", i));

        // Reset-done loss in WAIT_DONE of the second attempt.
        r_errs   = 1;
        r_hang   = 1'b1;
        r_delay  = 5;
        attempt  = 0;
        n_starts = 0;
        user_start_in = 1'b1;
        @(negedge clk);
        user_start_in = 1'b0;
        k = 0;
        while (n_starts < 2 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("loss: second attempt reached", n_starts, 2);
        repeat (3) @(negedge clk);
        tx_resetdone_in = 1'b0;
        @(negedge clk);
        check("loss wait_done: busy", int'(busy_out), 0);
        check("loss wait_done: aligned", int'(aligned_out), 0);
        check("loss wait_done: retry held", int'(retry_count_out), 1);
        run_seq(again, "restore1");

        // Reset-done loss in ALIGNED.
        tx_resetdone_in = 1'b0;
        @(negedge clk);
        check("loss aligned: aligned", int'(aligned_out), 0);
        check("loss aligned: busy", int'(busy_out), 0);
        run_seq(again, "restore2");

        // Sync reset during HOLDOFF.
        user_start_in = 1'b1;
        @(negedge clk);
        user_start_in = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-reset in holdoff", int'(busy_out), 1);
        rst             = 1'b1;
        tx_resetdone_in = 1'b0;
        @(negedge clk);
        check("reset abort outputs", int'({bb_reset_out, bb_start_out, aligned_out, fail_out,
                                           busy_out, retry_count_out}), 0);
        s   = n_starts;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({bb_reset_out, bb_start_out, aligned_out, fail_out, busy_out, retry_count_out} != 0)
                bad++;
        end
        check("outputs quiet during reset", bad, 0);
        check("no start during reset", n_starts, s);
        rst = 1'b0;
        @(negedge clk);
        run_seq(again, "after_reset");

        check("pulse overlap violations", viol, 0);
        check("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
